unidad_aritmetica_seg: RTL
==========================

# unidad_aritmetica_seg

- Pipelined, parametrised signed fixed-point arithmetic unit for the filter datapath.
- Supports add, subtract, multiply, multiply-accumulate and accumulator load, with a valid handshake and a fixed 2-cycle latency.
- Per-result overflow detection; optional saturation.
- Sits between the coefficient/sample registers and the filter output stage.

## Interface
- N, 25: operand and result width (signed two's complement).
- FRAC, 0: fractional bits; products are arithmetically right-shifted by FRAC.
- GUARD, 4: extra accumulator MSBs; accumulator width is N+GUARD.
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  a, b, func are sampled on this edge when high.
- a  input  N  signed operand.
- b  input  N  signed operand.
- func  input  3  operation select.
- valid_out  output  1  y, y1 and overflow hold a new result this cycle.
- y  output  N  signed result.
- y1  output  2N  full-precision signed product, unshifted.
- overflow  output  1  true result of the current op does not fit in N bits.

## Operation
- func 0: y = a+b.
- func 1: y = a−b.
- func 2: y = (a*b)>>>FRAC.
- func 3: acc = acc + ((a*b)>>>FRAC); y = new acc reduced to N bits.
- func 4: acc = (a*b)>>>FRAC (load, prior contents discarded); y = new acc reduced to N bits.
- func 5–7: y = 0, y1 = 0, overflow = 0, acc unchanged; valid_out still pulses.
- y1 = exact 2N-bit product for func 2/3/4; 0 otherwise.
- Shift truncates toward −inf; no rounding.
- Stage 1 registers the operands, the full-precision sum/difference (N+1 bits) and the product (2N bits).
- Stage 2 performs scaling, accumulation, overflow detection and N-bit reduction, then registers the outputs.
- overflow = 1 when the pre-reduction value lies outside [−2^(N−1), 2^(N−1)−1].
- Accumulator overflow (beyond N+GUARD bits):
  - saturates when UA_SATURACION_EN is defined;
  - wraps otherwise.
  - Either way it also sets overflow for that result.
- valid_in low inserts a bubble: acc unchanged; y, y1 and overflow hold their last values; valid_out = 0 at the corresponding output cycle.
- Back-to-back func 3 on consecutive cycles must accumulate every term. The accumulator read-modify-write completes within stage 2, so no forwarding hazard is permitted.

## Timing
- Latency: inputs sampled at edge k; outputs and valid_out = 1 after edge k+2.
- Throughput: one operation per cycle, no stall, no ready signal.
- Reset (reset_n low, asynchronous): y = 0, y1 = 0, overflow = 0, valid_out = 0, acc = 0, pipeline valid bits = 0.
- Reset asserted mid-operation discards in-flight operations; no valid_out follows deassertion until new valid_in.
- Reset is released synchronously to clk by the system; the block does not resynchronise it.

## Configuration
- UA_SATURACION_EN defined:
  - on overflow, y clamps to 2^(N−1)−1 (positive) or −2^(N−1) (negative);
  - the accumulator clamps to its own N+GUARD limits.
- UA_SATURACION_EN undefined:
  - y = low N bits of the true result (wrap);
  - the accumulator wraps modulo 2^(N+GUARD).
- overflow is reported identically in both builds.

## Test plan
- N=25, FRAC=0; a=−2731, b=2731 (a = 0x1FFF555 as 25-bit two's complement), func 0/1/2 on successive cycles:
  - y = 0, −5462, −7458361 on three consecutive cycles starting two edges after the first sample;
  - y1 = −7458361 (50-bit) for func 2;
  - overflow = 0 throughout.
- a=16777215, b=1, func 0:
  - with UA_SATURACION_EN: y = 16777215, overflow = 1;
  - without: y = −16777216, overflow = 1.
- FRAC=12; a=b=4096 (1.0), func 2 → y = 4096, y1 = 16777216.
- FRAC=0, back-to-back func 4 (a=2, b=3) then func 3 (a=4, b=5) then func 3 (a=−1, b=26) → y = 6, 26, 0 on consecutive cycles.
- valid_in pattern 1,0,1 with func 0 → valid_out pattern 1,0,1 two cycles later; y holds during the bubble.
- Pulse reset_n low while two operations are in flight → valid_out = 0, y = 0, acc = 0 immediately; subsequent func 3 (a=1, b=1) → y = 1.

Source files
------------

// File: rtl/unidad_aritmetica_seg.sv
// Pipelined signed fixed-point add/sub/mul/MAC unit with a fixed 2-cycle latency.
// Define UA_SATURACION_EN to saturate results and accumulator instead of wrapping.
module unidad_aritmetica_seg #(
    parameter int unsigned N     = 25,
    parameter int unsigned FRAC  = 0,
    parameter int unsigned GUARD = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [2:0]       func,
    output logic             valid_out,
    output logic [N-1:0]     y,
    output logic [2*N-1:0]   y1,
    output logic             overflow
);

    localparam int unsigned SW = N + 1;
    localparam int unsigned PW = 2 * N;
    localparam int unsigned AW = N + GUARD;
    localparam int unsigned EW = 2 * N + GUARD + 2;

    localparam logic signed [EW-1:0] YMAX = {{(EW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [EW-1:0] YMIN = {{(EW-N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic signed [EW-1:0] AMAX = {{(EW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [EW-1:0] AMIN = {{(EW-AW+1){1'b1}}, {(AW-1){1'b0}}};

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_MUL = 3'd2;
    localparam logic [2:0] F_MAC = 3'd3;
    localparam logic [2:0] F_LDA = 3'd4;

    // operand capture
    logic            v0;
    logic [N-1:0]    a0;
    logic [N-1:0]    b0;
    logic [2:0]      f0;

    // stage 1 results
    logic                  v1;
    logic [2:0]            f1;
    logic signed [SW-1:0]  sum1;
    logic signed [PW-1:0]  prod1;
    logic signed [SW-1:0]  sum_c;
    logic signed [PW-1:0]  prod_c;

    // stage 2 combinational
    logic signed [AW-1:0]  acc;
    logic signed [PW-1:0]  scaled_c;
    logic signed [EW-1:0]  scaled_x;
    logic signed [EW-1:0]  acc_x;
    logic signed [EW-1:0]  accsum_c;
    logic signed [AW-1:0]  acc_new_c;
    logic signed [EW-1:0]  res_c;
    logic                  acc_op_c;
    logic                  acc_ovf_c;
    logic                  y_ovf_c;
    logic [N-1:0]          y_c;
    logic [PW-1:0]         y1_c;
    logic                  ovf_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v0 <= 1'b0;
            a0 <= '0;
            b0 <= '0;
            f0 <= '0;
        end else begin
            v0 <= valid_in;
            if (valid_in) begin
                a0 <= a;
                b0 <= b;
                f0 <= func;
            end
        end
    end

    // full-precision sum/difference and product
    always_comb begin
        sum_c  = (f0 == F_SUB) ? ({a0[N-1], a0} - {b0[N-1], b0})
                               : ({a0[N-1], a0} + {b0[N-1], b0});
        prod_c = {{N{a0[N-1]}}, a0} * {{N{b0[N-1]}}, b0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1    <= 1'b0;
            f1    <= '0;
            sum1  <= '0;
            prod1 <= '0;
        end else begin
            v1 <= v0;
            if (v0) begin
                f1    <= f0;
                sum1  <= sum_c;
                prod1 <= prod_c;
            end
        end
    end

    // scaling, accumulation, overflow detection and N-bit reduction
    always_comb begin
        scaled_c  = prod1 >>> FRAC;
        scaled_x  = {{(EW-PW){scaled_c[PW-1]}}, scaled_c};
        acc_x     = {{(EW-AW){acc[AW-1]}}, acc};
        acc_op_c  = (f1 == F_MAC) || (f1 == F_LDA);
        accsum_c  = (f1 == F_MAC) ? (acc_x + scaled_x) : scaled_x;
        acc_ovf_c = (accsum_c > AMAX) || (accsum_c < AMIN);
`ifdef UA_SATURACION_EN
        if (acc_ovf_c) begin
            acc_new_c = accsum_c[EW-1] ? AMIN[AW-1:0] : AMAX[AW-1:0];
        end else begin
            acc_new_c = accsum_c[AW-1:0];
        end
`else
        acc_new_c = accsum_c[AW-1:0];
`endif
        res_c = '0;
        y1_c  = '0;
        case (f1)
            F_ADD, F_SUB: res_c = {{(EW-SW){sum1[SW-1]}}, sum1};
            F_MUL: begin
                res_c = scaled_x;
                y1_c  = prod1;
            end
            F_MAC, F_LDA: begin
                res_c = {{(EW-AW){acc_new_c[AW-1]}}, acc_new_c};
                y1_c  = prod1;
            end
            default: res_c = '0;
        endcase
        y_ovf_c = (res_c > YMAX) || (res_c < YMIN);
`ifdef UA_SATURACION_EN
        if (y_ovf_c) begin
            y_c = res_c[EW-1] ? YMIN[N-1:0] : YMAX[N-1:0];
        end else begin
            y_c = res_c[N-1:0];
        end
`else
        y_c = res_c[N-1:0];
`endif
        ovf_c = y_ovf_c || (acc_op_c && acc_ovf_c);
    end

    // bubbles leave outputs and accumulator untouched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_out <= 1'b0;
            y         <= '0;
            y1        <= '0;
            overflow  <= 1'b0;
            acc       <= '0;
        end else begin
            valid_out <= v1;
            if (v1) begin
                y        <= y_c;
                y1       <= y1_c;
                overflow <= ovf_c;
                if (acc_op_c) begin
                    acc <= acc_new_c;
                end
            end
        end
    end

endmodule
